// File: rtl/cp0_irq_timer_pkg.sv
// rtl/cp0_irq_timer_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_irq_timer_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_IBE  = 5'd6;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_NONE = 5'd31;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 8;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] PRID_DEFAULT = 32'h0000_4C31;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and sticky timer interrupt
module cp0_timer
    import cp0_irq_timer_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_irq
);

    localparam int PS_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(COUNT_DIV - 1);

    logic [PS_W-1:0] prescaler;
    logic            armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            count     <= '0;
        end else if (count_we) begin
            prescaler <= '0;
            count     <= wdata;
        end else if (prescaler == PS_MAX) begin
            prescaler <= '0;
            count     <= count + 32'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // A Compare write acknowledges the interrupt and beats a same-cycle match.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare   <= '0;
            armed     <= 1'b0;
            timer_irq <= 1'b0;
        end else if (compare_we) begin
            compare   <= wdata;
            armed     <= 1'b1;
            timer_irq <= 1'b0;
        end else if (armed && (count == compare)) begin
            timer_irq <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_irq_timer.sv
// rtl/cp0_irq_timer.sv - CP0 with SR/Cause/EPC/BadVAddr/PRId and optional Count/Compare timer (CP0_TIMER_EN)
module cp0_irq_timer
    import cp0_irq_timer_pkg::*;
#(
    parameter int          NUM_HWIRQ = 6,
    parameter logic [31:0] PRID_VAL  = PRID_DEFAULT,
    parameter int          COUNT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           addr,
    input  logic                 write_enable,
    input  logic [31:0]          write_data,
    input  logic                 exit_isr,
    input  logic                 in_bds,
    input  logic [NUM_HWIRQ-1:0] hwirq,
    input  logic [4:0]           exc,
    input  logic [31:0]          curr_pc,
    input  logic [31:0]          bad_vaddr,
    output logic [31:0]          read_result,
    output logic [31:0]          epc,
    output logic                 have2handle,
    output logic                 timer_irq
);

    if (NUM_HWIRQ < 1 || NUM_HWIRQ > 6) begin : g_bad_hwirq
        $error("NUM_HWIRQ out of range");
    end
    if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_div
        $error("COUNT_DIV out of range");
    end

    logic        sr_ie;
    logic        sr_exl;
    logic [7:0]  sr_im;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [1:0]  sw_ip;
    logic [31:0] badvaddr_q;
    logic [7:0]  ip;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        have_irq;
    logic        have_exc;
    logic        mtc0_ok;
    logic [4:0]  trap_code;

    always_comb begin
        ip                = '0;
        ip[1:0]           = sw_ip;
        ip[2 +: NUM_HWIRQ] = hwirq;
        ip[7]             = ip[7] | timer_irq;
    end

    assign sr_val    = {16'b0, sr_im, 6'b0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'b0, ip, 1'b0, cause_exc, 2'b0};

    assign have_irq    = (|(ip & sr_im)) && sr_ie && !sr_exl;
    assign have_exc    = (exc != EXC_NONE) && !sr_exl;
    assign have2handle = have_irq || have_exc;
    assign trap_code   = have_irq ? EXC_INT : exc;
    // Trap entry swallows any mtc0 in the same cycle, timer writes included.
    assign mtc0_ok     = write_enable && !have2handle;

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (mtc0_ok && (addr == CP0_COUNT)),
        .compare_we (mtc0_ok && (addr == CP0_COMPARE)),
        .wdata      (write_data),
        .count      (count_val),
        .compare    (compare_val),
        .timer_irq  (timer_irq)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign timer_irq   = 1'b0;
`endif

    always_comb begin
        read_result = '0;
        case (addr)
            CP0_BADVADDR: read_result = badvaddr_q;
            CP0_COUNT:    read_result = count_val;
            CP0_COMPARE:  read_result = compare_val;
            CP0_SR:       read_result = sr_val;
            CP0_CAUSE:    read_result = cause_val;
            CP0_EPC:      read_result = epc;
            CP0_PRID:     read_result = PRID_VAL;
            default:      read_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_ie      <= 1'b0;
            sr_exl     <= 1'b0;
            sr_im      <= '0;
            cause_bd   <= 1'b0;
            cause_exc  <= '0;
            sw_ip      <= '0;
            epc        <= '0;
            badvaddr_q <= '0;
        end else if (have2handle) begin
            sr_exl    <= 1'b1;
            cause_bd  <= in_bds;
            cause_exc <= trap_code;
            epc       <= in_bds ? (curr_pc - 32'd4) : curr_pc;
            if (is_addr_exc(trap_code)) begin
                badvaddr_q <= bad_vaddr;
            end
        end else if (write_enable) begin
            // Any mtc0 outranks eret, so EXL only follows write_data here.
            case (addr)
                CP0_SR: begin
                    sr_ie  <= write_data[SR_IE];
                    sr_exl <= write_data[SR_EXL];
                    sr_im  <= write_data[SR_IM_LO +: 8];
                end
                CP0_CAUSE: sw_ip <= write_data[CAUSE_IP_LO +: 2];
                CP0_EPC:   epc   <= write_data;
                default: ;
            endcase
        end else if (exit_isr) begin
            sr_exl <= 1'b0;
        end
    end

endmodule

// File: doc/cp0_irq_timer.md
Name: cp0_irq_timer

Overview:
Second-generation system-control coprocessor for the MIPS-subset pipeline. It holds SR, Cause, EPC, BadVAddr and PRId, with a parametrised hardware-interrupt count and writable software interrupts. It adds a Count/Compare timer that raises a sticky timer interrupt. It sits beside the M stage, takes exception/IRQ decisions from it, and supplies EPC plus the trap request to the PC-select logic.

Parameters:
NUM_HWIRQ, 6, external hardware IRQ lines (1..6), mapped to Cause.IP/SR.IM bits [10 +: NUM_HWIRQ]
PRID_VAL, 32'h0000_4C31, value read from PRId (reg 15)
COUNT_DIV, 2, clock cycles per Count increment (1..16)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  5  CP0 register number for mfc0/mtc0
write_enable  in  1  mtc0 strobe
write_data  in  32  mtc0 data
exit_isr  in  1  eret retiring this cycle
in_bds  in  1  faulting instruction is in a branch delay slot
hwirq  in  NUM_HWIRQ  level-sensitive external IRQs
exc  in  5  exception code of M-stage instruction (EXC_NONE = none)
curr_pc  in  32  PC of M-stage instruction
bad_vaddr  in  32  faulting address, valid with AdEL/AdES
read_result  out  32  mfc0 data (combinational on addr)
epc  out  32  EPC register
have2handle  out  1  take trap this cycle (combinational)
timer_irq  out  1  sticky timer-interrupt flag

Behaviour:
- Clock is clk; reset is synchronous, active-high, named rst. On reset: SR=0, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0, armed=0, timer_irq=0.
- SR fields: IE=bit0, EXL=bit1, IM=bits[15:8]; all other bits read 0. Cause fields: ExcCode=[6:2], IP=[15:8], BD=bit31.
- Cause.IP[9:8] are software interrupts, writable by mtc0 to reg 13; all other Cause bits are read-only to mtc0.
- Cause.IP[10 +: NUM_HWIRQ] sample hwirq every cycle. IP bit 15 is additionally ORed with timer_irq. Unused IP bits read 0.
- have_irq = |(IP & IM) & IE & !EXL. have_exc = (exc != EXC_NONE) & !EXL. have2handle = have_irq | have_exc.
- Trap entry (next edge): EXL<=1; BD<=in_bds; EPC<=in_bds ? curr_pc-4 : curr_pc (32-bit wrap).
  - ExcCode<=EXC_INT if have_irq, else exc.
  - BadVAddr<=bad_vaddr only when ExcCode is AdEL or AdES.
- Priority in one cycle: trap entry > mtc0 > exit_isr. When trap entry and mtc0 coincide, the mtc0 is dropped. When mtc0 and exit_isr coincide, EXL is not cleared.
- exit_isr alone: EXL<=0 next edge.
- Writable registers: 12, 13 (SW IP only), 14, and 9/11 when the timer is built. Unlisted addresses read 0; writes to them are ignored.
- Timer:
  - The prescaler counts 0..COUNT_DIV-1; Count increments (wraps at 2^32) when the prescaler reaches COUNT_DIV-1.
  - mtc0 Count loads Count and zeroes the prescaler.
  - mtc0 Compare loads Compare, sets armed=1, and clears timer_irq.
  - When armed and Count==Compare, timer_irq<=1 and stays set until the next Compare write.
  - If a Compare write and a match occur in the same cycle, the write wins and timer_irq=0.

Optional Feature:
CP0_TIMER_EN:
- Defined: Count (reg 9), Compare (reg 11), prescaler and timer_irq are built as specified above.
- Undefined: regs 9/11 read 0, writes to them are ignored, timer_irq is tied 0, and IP bit 15 reflects hwirq only.

Decomposition:
- Shared header cp0.h: register numbers (SR/CAUSE/EPC/PRID/COUNT/COMPARE/BADVADDR), EXC_* codes (EXC_NONE, EXC_INT, EXC_ADEL, EXC_ADES, ...), field bit positions, default PRID.
- One sub-module cp0_timer: prescaler, Count, Compare, armed and timer_irq, with its own write strobes.

Test Plan:
- Reset, then SR=0x0000_0401, hwirq[0]=1 -> have2handle=1 the same cycle; next edge ExcCode=0, EXL=1, EPC=curr_pc; second hwirq ignored while EXL=1.
- exc=AdEL with in_bds=1, curr_pc=0x3008, bad_vaddr=0x1003 -> EPC=0x3004, BD=1, BadVAddr=0x1003, ExcCode=4.
- mtc0 Cause=0x0000_0100 with SR=0x0000_0101 -> IP[8]=1 and have2handle=1; subsequent mtc0 Cause=0 clears it.
- COUNT_DIV=2, mtc0 Compare=5 at Count=0 -> timer_irq rises when Count reaches 5 (cycle ~10); mtc0 Compare=20 clears it.
- Same cycle: have_exc with mtc0 EPC=0xDEAD -> EPC=curr_pc (write dropped). Same cycle: exit_isr with mtc0 SR -> SR=write_data and EXL is not cleared.
- rst asserted mid-ISR with timer_irq=1 and EXL=1 -> all registers zero next edge and timer_irq=0 until Compare is rewritten.
